// File: rtl/inst_fetch_queue.sv
// Fetch queue: issues PCs to instruction memory, collects in-order responses, hands {inst, pc} to decode.
// Fill is registered (MemRValid -> InstValid is 1 cycle); stale in-flight responses are dropped after Redirect.
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [31:0]   PCIn,
  input  logic          PCValid,
  output logic          PCReady,
  input  logic          Redirect,
  output logic          MemReq,
  output logic [31:0]   MemAddr,
  input  logic          MemGnt,
  input  logic          MemRValid,
  input  logic [31:0]   MemRData,
  output logic          InstValid,
  output logic [31:0]   InstData,
  output logic [31:0]   InstPC,
  input  logic          InstReady,
  output logic          ProtoErr,
  output logic [CW-1:0] Occupancy
);

  localparam int PW = CW - 1;

  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [PW-1:0]    head_q, fill_q, tail_q;
  logic [CW-1:0]    alloc_cnt, drop_cnt;
  logic             proto_err_q;

  logic [CW:0]      budget;
  logic             credit;
  logic [CW-1:0]    filled_cnt, unfilled, redir_total;
  logic             pop, rsp_drop, rsp_fill, rsp_err;

  always_comb begin
    filled_cnt = '0;
    for (int i = 0; i < DEPTH; i++)
      filled_cnt = filled_cnt + CW'(filled_q[i]);
  end

  assign unfilled    = alloc_cnt - filled_cnt;
  assign redir_total = drop_cnt + unfilled;
  assign budget      = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
  assign credit      = budget < (CW+1)'(DEPTH);

  assign MemReq  = PCValid & credit & ~Redirect & ~RST;
  assign MemAddr = {PCIn[31:2], 2'b00};
  assign PCReady = MemReq & MemGnt;

  assign InstValid = filled_q[head_q] & ~Redirect;
  assign InstData  = (alloc_cnt != '0) ? data_q[head_q] : '0;
  assign InstPC    = (alloc_cnt != '0) ? pc_q[head_q]   : '0;
  assign Occupancy = alloc_cnt;
  assign ProtoErr  = proto_err_q;

  assign pop = InstValid & InstReady;

  // Filling is keyed on an unfilled allocated entry existing, so a response
  // with no matching request can never land in an unallocated slot.
  always_comb begin
    rsp_drop = 1'b0;
    rsp_fill = 1'b0;
    rsp_err  = 1'b0;
    if (MemRValid) begin
      if (Redirect)
        rsp_err = (redir_total == '0);
      else if (drop_cnt != '0)
        rsp_drop = 1'b1;
      else if (unfilled != '0)
        rsp_fill = 1'b1;
      else
        rsp_err = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q      <= '0;
      fill_q      <= '0;
      tail_q      <= '0;
      alloc_cnt   <= '0;
      drop_cnt    <= '0;
      filled_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (rsp_err)
        proto_err_q <= 1'b1;
      if (Redirect) begin
        // A response in the redirect cycle retires one of the outstanding requests.
        drop_cnt  <= (MemRValid && redir_total != '0) ? redir_total - CW'(1) : redir_total;
        head_q    <= '0;
        fill_q    <= '0;
        tail_q    <= '0;
        alloc_cnt <= '0;
        filled_q  <= '0;
      end else begin
        if (PCReady) begin
          filled_q[tail_q] <= 1'b0;
          tail_q           <= tail_q + PW'(1);
        end
        if (rsp_fill) begin
          filled_q[fill_q] <= 1'b1;
          fill_q           <= fill_q + PW'(1);
        end
        if (pop) begin
          filled_q[head_q] <= 1'b0;
          head_q           <= head_q + PW'(1);
        end
        if (rsp_drop)
          drop_cnt <= drop_cnt - CW'(1);
        alloc_cnt <= alloc_cnt + CW'(PCReady) - CW'(pop);
      end
    end
  end

  // Payload storage needs no reset; InstData/InstPC are masked while empty.
  always_ff @(posedge CLK) begin
    if (PCReady)
      pc_q[tail_q] <= PCIn;
    if (rsp_fill)
      data_q[fill_q] <= MemRData;
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: in-order fetch, full stall, redirect drop, protocol error, async reset.
module tb_inst_fetch_queue;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [31:0]   PCIn = '0;
  logic          PCValid = 1'b0;
  logic          PCReady;
  logic          Redirect = 1'b0;
  logic          MemReq;
  logic [31:0]   MemAddr;
  logic          MemGnt = 1'b1;
  logic          MemRValid = 1'b0;
  logic [31:0]   MemRData = '0;
  logic          InstValid;
  logic [31:0]   InstData;
  logic [31:0]   InstPC;
  logic          InstReady = 1'b0;
  logic          ProtoErr;
  logic [CW-1:0] Occupancy;

  int n_checks = 0;
  int n_pass   = 0;

  inst_fetch_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .CLK(CLK), .RST(RST), .PCIn(PCIn), .PCValid(PCValid), .PCReady(PCReady),
    .Redirect(Redirect), .MemReq(MemReq), .MemAddr(MemAddr), .MemGnt(MemGnt),
    .MemRValid(MemRValid), .MemRData(MemRData), .InstValid(InstValid),
    .InstData(InstData), .InstPC(InstPC), .InstReady(InstReady),
    .ProtoErr(ProtoErr), .Occupancy(Occupancy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    PCIn = '0; PCValid = 1'b0; Redirect = 1'b0; MemGnt = 1'b1;
    MemRValid = 1'b0; MemRData = '0; InstReady = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    cycle();
    cycle();
    RST = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants;
    logic [31:0] pc;

    // Reset state, with PCValid high to show MemReq is held low by RST.
    idle_inputs();
    PCValid = 1'b1; PCIn = 32'h1234;
    cycle(); cycle();
    check("rst_memreq",    32'(MemReq),    0);
    check("rst_pcready",   32'(PCReady),   0);
    check("rst_instvalid", 32'(InstValid), 0);
    check("rst_instdata",  InstData,       0);
    check("rst_instpc",    InstPC,         0);
    check("rst_occ",       32'(Occupancy), 0);
    check("rst_protoerr",  32'(ProtoErr),  0);
    RST = 1'b0;
    idle_inputs();

    // 1: three fetches, 2-cycle memory latency, decode always ready.
    InstReady = 1'b1; PCValid = 1'b1; PCIn = 32'h3000;
    #1;
    check("t1_memreq",  32'(MemReq),  1);
    check("t1_pcready", 32'(PCReady), 1);
    check("t1_addr",    MemAddr,      32'h3000);
    cycle();
    PCIn = 32'h3004;
    cycle();
    PCIn = 32'h3008; MemRValid = 1'b1; MemRData = 32'hA0;
    #1;
    check("t1_no_bypass", 32'(InstValid), 0);
    check("t1_occ2",      32'(Occupancy), 2);
    cycle();
    PCValid = 1'b0; MemRData = 32'hA1;
    #1;
    check("t1_v0",  32'(InstValid), 1);
    check("t1_pc0", InstPC,   32'h3000);
    check("t1_d0",  InstData, 32'hA0);
    cycle();
    MemRData = 32'hA2;
    #1;
    check("t1_v1",  32'(InstValid), 1);
    check("t1_pc1", InstPC,   32'h3004);
    check("t1_d1",  InstData, 32'hA1);
    cycle();
    MemRValid = 1'b0;
    #1;
    check("t1_v2",  32'(InstValid), 1);
    check("t1_pc2", InstPC,   32'h3008);
    check("t1_d2",  InstData, 32'hA2);
    cycle();
    check("t1_empty_v",   32'(InstValid), 0);
    check("t1_empty_occ", 32'(Occupancy), 0);

    // 2: decode stalled, continuous PCValid -> exactly DEPTH grants.
    do_reset();
    InstReady = 1'b0; PCValid = 1'b1; grants = 0; pc = 32'h5000;
    for (int i = 0; i < 6; i++) begin
      PCIn = pc;
      #1;
      if (PCReady) begin
        grants++;
        pc = pc + 32'd4;
      end
      cycle();
    end
    check("t2_grants", 32'(grants), 4);
    check("t2_full_pcready", 32'(PCReady),   0);
    check("t2_full_occ",     32'(Occupancy), 4);
    for (int i = 0; i < 4; i++) begin
      MemRValid = 1'b1; MemRData = 32'hB0 + 32'(i);
      #1;
      check("t2_full_stall", 32'(PCReady), 0);
      cycle();
    end
    MemRValid = 1'b0; InstReady = 1'b1;
    #1;
    check("t2_pop_v",        32'(InstValid), 1);
    check("t2_pop_pc",       InstPC,         32'h5000);
    check("t2_pop_d",        InstData,       32'hB0);
    check("t2_pop_pcready",  32'(PCReady),   0);
    cycle();
    InstReady = 1'b0;
    #1;
    check("t2_refill_pcready", 32'(PCReady),   1);
    check("t2_refill_occ",     32'(Occupancy), 3);
    check("t2_refill_addr",    MemAddr,        32'h5010);
    cycle();
    check("t2_refull_pcready", 32'(PCReady),   0);
    check("t2_refull_occ",     32'(Occupancy), 4);
    check("t2_head_pc",        InstPC,         32'h5004);
    check("t2_head_d",         InstData,       32'hB1);

    // 3: three requests in flight, redirect, stale responses dropped.
    do_reset();
    PCValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      PCIn = 32'h3000 + 32'(4 * i);
      cycle();
    end
    PCValid = 1'b0; Redirect = 1'b1;
    #1;
    check("t3_redir_memreq", 32'(MemReq),    0);
    check("t3_redir_valid",  32'(InstValid), 0);
    cycle();
    Redirect = 1'b0; PCValid = 1'b1; PCIn = 32'h4000;
    #1;
    check("t3_first_pcready", 32'(PCReady),   1);
    check("t3_post_occ",      32'(Occupancy), 0);
    cycle();
    PCIn = 32'h4004; MemRValid = 1'b1; MemRData = 32'hDEAD0;
    #1;
    check("t3_drop_credit", 32'(PCReady), 0);
    cycle();
    PCValid = 1'b0; MemRData = 32'hDEAD1;
    #1;
    check("t3_stale1_v", 32'(InstValid), 0);
    cycle();
    MemRData = 32'hDEAD2;
    #1;
    check("t3_stale2_v", 32'(InstValid), 0);
    cycle();
    MemRData = 32'h4444;
    #1;
    check("t3_stale3_v", 32'(InstValid), 0);
    cycle();
    MemRValid = 1'b0; InstReady = 1'b1;
    #1;
    check("t3_new_v",   32'(InstValid), 1);
    check("t3_new_pc",  InstPC,         32'h4000);
    check("t3_new_d",   InstData,       32'h4444);
    check("t3_no_perr", 32'(ProtoErr),  0);
    cycle();
    check("t3_drained", 32'(Occupancy), 0);

    // 4: redirect coincides with a response and a pop of a filled head.
    do_reset();
    PCValid = 1'b1; PCIn = 32'h3000;
    cycle();
    PCIn = 32'h3004; MemRValid = 1'b1; MemRData = 32'hC0;
    cycle();
    PCValid = 1'b0; MemRValid = 1'b0;
    #1;
    check("t4_head_v", 32'(InstValid), 1);
    Redirect = 1'b1; MemRValid = 1'b1; MemRData = 32'hC1; InstReady = 1'b1;
    #1;
    check("t4_redir_v",      32'(InstValid), 0);
    check("t4_redir_memreq", 32'(MemReq),    0);
    cycle();
    Redirect = 1'b0; MemRValid = 1'b0; InstReady = 1'b0;
    #1;
    check("t4_occ",   32'(Occupancy), 0);
    check("t4_v",     32'(InstValid), 0);
    check("t4_perr",  32'(ProtoErr),  0);
    // Nothing left to drop, so all DEPTH slots must be grantable.
    PCValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      PCIn = 32'h4002 + 32'(4 * i);
      #1;
      check("t4_credit", 32'(PCReady), 1);
      if (i == 0) check("t4_addr_align", MemAddr, 32'h4000);
      cycle();
    end
    check("t4_full_pcready", 32'(PCReady),   0);
    check("t4_full_occ",     32'(Occupancy), 4);

    // 5: response with nothing outstanding.
    do_reset();
    MemRValid = 1'b1; MemRData = 32'hEE;
    cycle();
    MemRValid = 1'b0;
    #1;
    check("t5_perr",   32'(ProtoErr),  1);
    check("t5_occ",    32'(Occupancy), 0);
    check("t5_v",      32'(InstValid), 0);
    cycle();
    check("t5_sticky", 32'(ProtoErr),  1);
    RST = 1'b1;
    #1;
    check("t5_rst_clear", 32'(ProtoErr), 0);
    cycle();
    RST = 1'b0;

    // 6: asynchronous reset with three entries allocated.
    PCValid = 1'b1; PCIn = 32'h3000;
    cycle();
    PCIn = 32'h3004; MemRValid = 1'b1; MemRData = 32'hD0;
    cycle();
    PCIn = 32'h3008; MemRValid = 1'b0;
    cycle();
    PCIn = 32'h300C;
    #1;
    check("t6_pre_occ",    32'(Occupancy), 3);
    check("t6_pre_v",      32'(InstValid), 1);
    check("t6_pre_memreq", 32'(MemReq),    1);
    RST = 1'b1;
    #1;
    check("t6_async_v",      32'(InstValid), 0);
    check("t6_async_d",      InstData,       0);
    check("t6_async_pc",     InstPC,         0);
    check("t6_async_memreq", 32'(MemReq),    0);
    check("t6_async_pcrdy",  32'(PCReady),   0);
    check("t6_async_occ",    32'(Occupancy), 0);
    cycle();
    idle_inputs();
    RST = 1'b0;
    PCValid = 1'b1; PCIn = 32'h3000;
    #1;
    check("t6_post_pcready", 32'(PCReady), 1);
    check("t6_post_addr",    MemAddr,      32'h3000);
    cycle();
    PCValid = 1'b0; MemRValid = 1'b1; MemRData = 32'hD5;
    cycle();
    MemRValid = 1'b0; InstReady = 1'b1;
    #1;
    check("t6_post_v",    32'(InstValid), 1);
    check("t6_post_pc",   InstPC,         32'h3000);
    check("t6_post_d",    InstData,       32'hD5);
    check("t6_post_perr", 32'(ProtoErr),  0);
    cycle();
    check("t6_post_occ",  32'(Occupancy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
